// File: rtl/can_tx_mailbox.sv
// Multi-mailbox CAN transmit buffer: holds NUM_MBOX frames, offers the highest
// priority pending frame to the frame engine, and handles retries, aborts and reporting.
module can_tx_mailbox #(
    parameter int unsigned NUM_MBOX    = 4,
    parameter int unsigned ID_SIZE     = 11,
    parameter int unsigned MAX_BYTES   = 8,
    parameter int unsigned RETRY_LIMIT = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_MBOX)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [ID_SIZE-1:0]     wr_id,
    input  logic                   wr_rtr,
    input  logic [3:0]             wr_dlc,
    input  logic [8*MAX_BYTES-1:0] wr_data,
    output logic                   wr_err,
    input  logic [NUM_MBOX-1:0]    abort_req,
    output logic [NUM_MBOX-1:0]    mbox_valid,
    output logic                   tx_req,
    output logic [IDX_W-1:0]       tx_idx,
    output logic [ID_SIZE-1:0]     tx_id,
    output logic                   tx_rtr,
    output logic [3:0]             tx_dlc,
    output logic [8*MAX_BYTES-1:0] tx_data,
    input  logic                   tx_ack,
    input  logic                   tx_done,
    input  logic [1:0]             tx_result,
    output logic [NUM_MBOX-1:0]    done_pulse,
    output logic [NUM_MBOX-1:0]    fail_pulse
);

    localparam int unsigned DATA_W  = 8 * MAX_BYTES;
    localparam int unsigned CNT_W   = (RETRY_LIMIT > 1) ? $clog2(RETRY_LIMIT + 1) : 1;
    localparam logic [3:0]  MAX_DLC = 4'(MAX_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_OFFER,
        ST_ACTIVE
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_MBOX-1:0]  valid_q, valid_d;
    logic [NUM_MBOX-1:0]  rtr_q, rtr_d;
    logic [ID_SIZE-1:0]   id_q    [NUM_MBOX];
    logic [ID_SIZE-1:0]   id_d    [NUM_MBOX];
    logic [3:0]           dlc_q   [NUM_MBOX];
    logic [3:0]           dlc_d   [NUM_MBOX];
    logic [DATA_W-1:0]    data_q  [NUM_MBOX];
    logic [DATA_W-1:0]    data_d  [NUM_MBOX];
    logic [CNT_W-1:0]     retry_q [NUM_MBOX];
    logic [CNT_W-1:0]     retry_d [NUM_MBOX];
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 wr_err_q, wr_err_d;
    logic [NUM_MBOX-1:0]  done_q, done_d;
    logic [NUM_MBOX-1:0]  fail_q, fail_d;

    logic [NUM_MBOX-1:0]  cand;
    logic                 best_found;
    logic [IDX_W-1:0]     best_idx;
    logic [ID_SIZE-1:0]   best_id;
    logic                 best_rtr;
    logic                 wr_in_range;
    logic                 abort_now;
    logic [CNT_W-1:0]     retry_next;

    assign wr_in_range = ({{(32-IDX_W){1'b0}}, wr_idx} < 32'(NUM_MBOX));

    // Winner search; mailboxes being aborted are masked out while latching a winner
    // so an aborted mailbox is never offered.
    always_comb begin
        cand       = valid_q & ((state_q == ST_SELECT) ? ~abort_req : '1);
        best_found = 1'b0;
        best_idx   = '0;
        best_id    = '0;
        best_rtr   = 1'b0;
        for (int unsigned i = 0; i < NUM_MBOX; i++) begin
            if (cand[i]) begin
                if (!best_found || (id_q[i] < best_id) ||
                    ((id_q[i] == best_id) && !rtr_q[i] && best_rtr)) begin
                    best_found = 1'b1;
                    best_idx   = IDX_W'(i);
                    best_id    = id_q[i];
                    best_rtr   = rtr_q[i];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        rtr_d        = rtr_q;
        id_d         = id_q;
        dlc_d        = dlc_q;
        data_d       = data_q;
        retry_d      = retry_q;
        sel_d        = sel_q;
        abort_pend_d = abort_pend_q;
        wr_err_d     = 1'b0;
        done_d       = '0;
        fail_d       = '0;
        abort_now    = 1'b0;
        retry_next   = '0;

        if (wr_en) begin
            if (wr_in_range && !valid_q[wr_idx]) begin
                valid_d[wr_idx] = 1'b1;
                id_d[wr_idx]    = wr_id;
                rtr_d[wr_idx]   = wr_rtr;
                dlc_d[wr_idx]   = (wr_dlc > MAX_DLC) ? MAX_DLC : wr_dlc;
                data_d[wr_idx]  = wr_data;
                retry_d[wr_idx] = '0;
            end else begin
                wr_err_d = 1'b1;
            end
        end

        // The offered/active mailbox defers its abort unless it is still only offered.
        for (int unsigned i = 0; i < NUM_MBOX; i++) begin
            if (abort_req[i] && valid_q[i]) begin
                if (((state_q == ST_OFFER) || (state_q == ST_ACTIVE)) && (IDX_W'(i) == sel_q)) begin
                    if ((state_q == ST_ACTIVE) || tx_ack) begin
                        abort_pend_d = 1'b1;
                    end else begin
                        valid_d[i] = 1'b0;
                        fail_d[i]  = 1'b1;
                    end
                end else begin
                    valid_d[i] = 1'b0;
                    fail_d[i]  = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (|valid_q) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (best_found) begin
                    sel_d   = best_idx;
                    state_d = ST_OFFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (tx_ack) begin
                    state_d = ST_ACTIVE;
                end else if (abort_req[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (best_found && (best_idx != sel_q)) begin
                    state_d = ST_SELECT;
                end
            end
            ST_ACTIVE: begin
                if (tx_done) begin
                    abort_now = abort_pend_q | abort_req[sel_q];
                    case (tx_result)
                        2'b00: begin
                            valid_d[sel_q] = 1'b0;
                            done_d[sel_q]  = 1'b1;
                        end
                        2'b01: begin
                            if (abort_now) begin
                                valid_d[sel_q] = 1'b0;
                                fail_d[sel_q]  = 1'b1;
                            end
                        end
                        default: begin
                            retry_next     = (retry_q[sel_q] != '1) ? retry_q[sel_q] + 1'b1 : retry_q[sel_q];
                            retry_d[sel_q] = retry_next;
                            if (((RETRY_LIMIT != 0) && (retry_next == CNT_W'(RETRY_LIMIT))) || abort_now) begin
                                valid_d[sel_q] = 1'b0;
                                fail_d[sel_q]  = 1'b1;
                            end
                        end
                    endcase
                    abort_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            rtr_q        <= '0;
            sel_q        <= '0;
            abort_pend_q <= 1'b0;
            wr_err_q     <= 1'b0;
            done_q       <= '0;
            fail_q       <= '0;
            for (int unsigned i = 0; i < NUM_MBOX; i++) begin
                id_q[i]    <= '0;
                dlc_q[i]   <= '0;
                data_q[i]  <= '0;
                retry_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rtr_q        <= rtr_d;
            sel_q        <= sel_d;
            abort_pend_q <= abort_pend_d;
            wr_err_q     <= wr_err_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            for (int unsigned i = 0; i < NUM_MBOX; i++) begin
                id_q[i]    <= id_d[i];
                dlc_q[i]   <= dlc_d[i];
                data_q[i]  <= data_d[i];
                retry_q[i] <= retry_d[i];
            end
        end
    end

    assign tx_req     = (state_q == ST_OFFER);
    assign tx_idx     = tx_req ? sel_q : '0;
    assign tx_id      = tx_req ? id_q[sel_q] : '0;
    assign tx_rtr     = tx_req ? rtr_q[sel_q] : 1'b0;
    assign tx_dlc     = tx_req ? dlc_q[sel_q] : '0;
    assign tx_data    = (tx_req && !rtr_q[sel_q]) ? data_q[sel_q] : '0;
    assign mbox_valid = valid_q;
    assign wr_err     = wr_err_q;
    assign done_pulse = done_q;
    assign fail_pulse = fail_q;

endmodule

// File: tb/tb_can_tx_mailbox.sv
// Scoreboard bench for can_tx_mailbox: stimulus queues expected events, a monitor
// process pops and compares them whenever the DUT presents an offer or a pulse.
module tb_can_tx_mailbox;

    localparam int IW  = 2;
    localparam int IDW = 11;
    localparam int K_OFFER = 0;
    localparam int K_WRERR = 1;
    localparam int K_DONE  = 2;
    localparam int K_FAIL  = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            wr_en = 1'b0;
    logic [IW-1:0]   wr_idx = '0;
    logic [IDW-1:0]  wr_id = '0;
    logic            wr_rtr = 1'b0;
    logic [3:0]      wr_dlc = '0;
    logic [63:0]     wr_data = '0;
    logic            wr_err;
    logic [3:0]      abort_req = '0;
    logic [3:0]      mbox_valid;
    logic            tx_req;
    logic [IW-1:0]   tx_idx;
    logic [IDW-1:0]  tx_id;
    logic            tx_rtr;
    logic [3:0]      tx_dlc;
    logic [63:0]     tx_data;
    logic            tx_ack = 1'b0;
    logic            tx_done = 1'b0;
    logic [1:0]      tx_result = '0;
    logic [3:0]      done_pulse;
    logic [3:0]      fail_pulse;

    can_tx_mailbox #(
        .NUM_MBOX(4), .ID_SIZE(11), .MAX_BYTES(8), .RETRY_LIMIT(3)
    ) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_id(wr_id), .wr_rtr(wr_rtr),
        .wr_dlc(wr_dlc), .wr_data(wr_data), .wr_err(wr_err),
        .abort_req(abort_req), .mbox_valid(mbox_valid),
        .tx_req(tx_req), .tx_idx(tx_idx), .tx_id(tx_id), .tx_rtr(tx_rtr),
        .tx_dlc(tx_dlc), .tx_data(tx_data),
        .tx_ack(tx_ack), .tx_done(tx_done), .tx_result(tx_result),
        .done_pulse(done_pulse), .fail_pulse(fail_pulse)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          idx;
        int          id;
        int          rtr;
        int          dlc;
        logic [63:0] data;
        int          mask;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_req = 1'b0;

    function automatic void push_offer(input int idx, input int id, input int rtr,
                                       input int dlc, input logic [63:0] data, input int c);
        exp_t e;
        e.kind = K_OFFER; e.idx = idx; e.id = id; e.rtr = rtr; e.dlc = dlc;
        e.data = data; e.mask = 0; e.cyc = c;
        sbq.push_back(e);
    endfunction

    function automatic void push_pulse(input int kind, input int mask, input int c);
        exp_t e;
        e.kind = kind; e.idx = 0; e.id = 0; e.rtr = 0; e.dlc = 0;
        e.data = '0; e.mask = mask; e.cyc = c;
        sbq.push_back(e);
    endfunction

    task automatic mon_check(input int kind, input int mask);
        exp_t e;
        bit   ok;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d mask=%b cyc=%0d tx_idx=%0d tx_id=%h, required no event",
                     kind, mask[3:0], cyc, tx_idx, tx_id);
            return;
        end
        e  = sbq.pop_front();
        ok = (e.kind == kind) && ((e.cyc < 0) || (e.cyc == cyc));
        if (kind == K_OFFER)
            ok = ok && (int'(tx_idx) == e.idx) && (int'(tx_id) == e.id) &&
                 (int'(tx_rtr) == e.rtr) && (int'(tx_dlc) == e.dlc) && (tx_data == e.data);
        else
            ok = ok && (mask == e.mask);
        if (!ok) begin
            bad++;
            $display("FAIL event got kind=%0d cyc=%0d idx=%0d id=%h rtr=%0d dlc=%0d data=%h mask=%b; required kind=%0d cyc=%0d idx=%0d id=%h rtr=%0d dlc=%0d data=%h mask=%b",
                     kind, cyc, tx_idx, tx_id, tx_rtr, tx_dlc, tx_data, mask[3:0],
                     e.kind, e.cyc, e.idx, e.id[10:0], e.rtr, e.dlc, e.data, e.mask[3:0]);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset) begin
                if (tx_req && !prev_req) mon_check(K_OFFER, 0);
                if (wr_err)              mon_check(K_WRERR, 0);
                if (|done_pulse)         mon_check(K_DONE, int'(done_pulse));
                if (|fail_pulse)         mon_check(K_FAIL, int'(fail_pulse));
            end
            prev_req = tx_req;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_mb(input int idx, input int id, input int rtr, input int dlc,
                            input logic [63:0] data, output int wc);
        wr_en   = 1'b1;
        wr_idx  = IW'(idx);
        wr_id   = IDW'(id);
        wr_rtr  = 1'(rtr);
        wr_dlc  = 4'(dlc);
        wr_data = data;
        wc      = cyc;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!tx_req && n < 60) begin
            tick();
            n++;
        end
        if (!tx_req) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got tx_req=0 want tx_req=1 within 60 cycles", nm);
        end
    endtask

    // Engine model: accept the offer, optionally abort while active, finish with res.
    task automatic run_frame(input logic [1:0] res, input int pulse_kind, input int mask,
                             input bit abort_mid);
        wait_req("offer");
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        if (abort_mid) abort_req = 4'(mask);
        tick();
        abort_req = '0;
        tick();
        if (pulse_kind >= 0) push_pulse(pulse_kind, mask, cyc + 1);
        tx_done   = 1'b1;
        tx_result = res;
        tick();
        tx_done   = 1'b0;
        tx_result = '0;
    endtask

    initial begin : stim
        int wc, wc2;

        repeat (3) tick();
        chk("rst_tx_req", 64'(tx_req), 64'd0);
        chk("rst_mbox_valid", 64'(mbox_valid), 64'd0);
        chk("rst_pulses", 64'({done_pulse, fail_pulse, wr_err}), 64'd0);
        chk("rst_tx_id", 64'(tx_id), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Single frame, cycle-exact offer latency.
        write_mb(0, 'h123, 0, 2, 64'hBEEF, wc);
        push_offer(0, 'h123, 0, 2, 64'hBEEF, wc + 3);
        run_frame(2'b00, K_DONE, 4'b0001, 1'b0);
        tick();
        chk("t1_mbox_valid", 64'(mbox_valid), 64'd0);

        // Priority ordering and DLC clamp.
        push_offer(1, 'h100, 0, 1, 64'hBB, -1);
        write_mb(2, 'h200, 0, 15, 64'hAA, wc);
        write_mb(1, 'h100, 0, 1, 64'hBB, wc);
        write_mb(3, 'h100, 1, 3, 64'hCC, wc);
        run_frame(2'b00, K_DONE, 4'b0010, 1'b0);
        push_offer(3, 'h100, 1, 3, 64'h0, -1);
        run_frame(2'b00, K_DONE, 4'b1000, 1'b0);
        push_offer(2, 'h200, 0, 8, 64'hAA, -1);
        run_frame(2'b00, K_DONE, 4'b0100, 1'b0);
        repeat (3) tick();

        // Pre-emption of a pending offer.
        write_mb(0, 'h300, 0, 1, 64'h11, wc);
        push_offer(0, 'h300, 0, 1, 64'h11, wc + 3);
        wait_req("t3_first");
        write_mb(1, 'h050, 0, 0, 64'h0, wc2);
        tick();
        chk("t3_req_dropped", 64'(tx_req), 64'd0);
        push_offer(1, 'h050, 0, 0, 64'h0, wc2 + 3);
        run_frame(2'b00, K_DONE, 4'b0010, 1'b0);
        push_offer(0, 'h300, 0, 1, 64'h11, -1);
        run_frame(2'b00, K_DONE, 4'b0001, 1'b0);
        repeat (3) tick();

        // Retry limit of 3 errors.
        write_mb(0, 'h010, 0, 1, 64'h5A, wc);
        push_offer(0, 'h010, 0, 1, 64'h5A, wc + 3);
        run_frame(2'b10, -1, 4'b0001, 1'b0);
        push_offer(0, 'h010, 0, 1, 64'h5A, -1);
        run_frame(2'b11, -1, 4'b0001, 1'b0);
        push_offer(0, 'h010, 0, 1, 64'h5A, -1);
        run_frame(2'b10, K_FAIL, 4'b0001, 1'b0);
        repeat (20) tick();
        chk("t4_mbox_valid", 64'(mbox_valid), 64'd0);

        // Abort while active: arbitration lost retires, ok completes.
        write_mb(0, 'h020, 0, 1, 64'h21, wc);
        push_offer(0, 'h020, 0, 1, 64'h21, wc + 3);
        run_frame(2'b01, K_FAIL, 4'b0001, 1'b1);
        repeat (15) tick();
        chk("t5a_mbox_valid", 64'(mbox_valid), 64'd0);
        write_mb(0, 'h021, 0, 1, 64'h22, wc);
        push_offer(0, 'h021, 0, 1, 64'h22, wc + 3);
        run_frame(2'b00, K_DONE, 4'b0001, 1'b1);
        repeat (15) tick();
        chk("t5b_mbox_valid", 64'(mbox_valid), 64'd0);

        // Abort of an idle mailbox, then of the offered one.
        write_mb(3, 'h700, 0, 1, 64'h33, wc);
        write_mb(2, 'h010, 0, 1, 64'h44, wc2);
        push_offer(2, 'h010, 0, 1, 64'h44, wc + 3);
        wait_req("t7");
        push_pulse(K_FAIL, 4'b1000, cyc + 1);
        abort_req = 4'b1000;
        tick();
        push_pulse(K_FAIL, 4'b0100, cyc + 1);
        abort_req = 4'b0100;
        tick();
        abort_req = '0;
        repeat (10) tick();
        chk("t7_mbox_valid", 64'(mbox_valid), 64'd0);
        chk("t7_tx_req", 64'(tx_req), 64'd0);

        // Write+abort same cycle, rejected rewrite, reset while active.
        abort_req = 4'b0010;
        write_mb(1, 'h055, 0, 1, 64'h77, wc);
        abort_req = '0;
        push_offer(1, 'h055, 0, 1, 64'h77, wc + 3);
        wait_req("t6");
        push_pulse(K_WRERR, 0, cyc + 1);
        write_mb(1, 'h066, 0, 2, 64'h88, wc2);
        tick();
        chk("t6_tx_id_kept", 64'(tx_id), 64'h055);
        chk("t6_tx_idx", 64'(tx_idx), 64'd1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        tick();
        chk("t6_active_valid", 64'(mbox_valid), 64'b0010);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_tx_req", 64'(tx_req), 64'd0);
        chk("t6_rst_mbox_valid", 64'(mbox_valid), 64'd0);
        chk("t6_rst_outs", 64'({done_pulse, fail_pulse, wr_err, tx_id, tx_dlc}), 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (10) tick();

        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL missing_events got remaining=%0d want remaining=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/can_tx_mailbox.md
Name: can_tx_mailbox

Overview:
Parametrised multi-mailbox transmit buffer that sits between the host and the CAN frame engine. It replaces the single-packet Tx path and its one-shot Retransmit flag. NUM_MBOX frames are held at once, and the pending frame with the highest CAN priority is offered to the engine. Per-mailbox retry limits, abort, and completion/failure reporting are handled here.

Parameters:
NUM_MBOX, 4, number of mailboxes (2..32)
ID_SIZE, 11, identifier width (11 standard, 29 extended)
MAX_BYTES, 8, payload bytes per mailbox (1..8)
RETRY_LIMIT, 16, error retransmissions before a frame fails; 0 means retry forever
IDX_W, $clog2(NUM_MBOX), mailbox index width (derived)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
wr_en  in  1  host write strobe
wr_idx  in  IDX_W  target mailbox
wr_id  in  ID_SIZE  frame identifier
wr_rtr  in  1  1 = remote frame
wr_dlc  in  4  data length code
wr_data  in  8*MAX_BYTES  payload, byte 0 in bits [7:0]
wr_err  out  1  pulse: write rejected
abort_req  in  NUM_MBOX  per-mailbox abort strobes
mbox_valid  out  NUM_MBOX  mailbox holds a pending frame
tx_req  out  1  frame offered to engine
tx_idx  out  IDX_W  offered mailbox
tx_id  out  ID_SIZE  offered identifier
tx_rtr  out  1  offered RTR
tx_dlc  out  4  offered DLC
tx_data  out  8*MAX_BYTES  offered payload
tx_ack  in  1  engine accepted offer (frame started)
tx_done  in  1  engine finished current frame
tx_result  in  2  00 ok, 01 arbitration lost, 10/11 error
done_pulse  out  NUM_MBOX  pulse: frame sent
fail_pulse  out  NUM_MBOX  pulse: frame retired unsent (retry limit or abort)

Behaviour:
- Reset: all outputs 0; all mailboxes invalid; retry counters 0; FSM in IDLE.
- Write: when wr_en is high and mailbox wr_idx is invalid, the fields are stored, the retry counter is cleared, and mbox_valid is set on the next edge.
- wr_dlc > MAX_BYTES is stored as MAX_BYTES. A remote frame keeps its DLC and drives tx_data to 0.
- A write to a valid mailbox is ignored and wr_err pulses for 1 cycle on the next edge.
- A write and an abort to the same invalid mailbox in the same cycle: the write takes effect and the abort is ignored.
- Priority order: lowest tx_id wins, then data frame over remote, then lowest index. The comparison is combinational over the valid mailboxes.
- IDLE: if any mailbox is valid, go to SELECT.
- SELECT: latch the winner index and go to OFFER. tx_req rises on the next edge, so a frame written in cycle N is offered at cycle N+3.
- OFFER: tx_req=1 and all tx_* fields hold stable until tx_ack.
  - On tx_ack: go to ACTIVE (tx_req drops on the same edge).
  - If a strictly higher-priority mailbox becomes valid before tx_ack: drop tx_req and go to SELECT.
  - If the offered mailbox is aborted before tx_ack: clear it, pulse fail_pulse, go to IDLE.
  - tx_ack and abort in the same cycle: tx_ack wins and the abort becomes pending.
- ACTIVE: wait for tx_done; the abort of the active mailbox is latched as pending. On tx_done:
  - ok: clear valid, pulse done_pulse, clear pending abort.
  - Arbitration lost: the retry counter is unchanged; if an abort is pending, retire with fail_pulse, else keep valid.
  - Error: increment the retry counter (saturating). If the counter reaches RETRY_LIMIT (with RETRY_LIMIT != 0) or an abort is pending, clear valid and pulse fail_pulse; otherwise keep valid.
  - In all cases go to IDLE (one-cycle gap before re-selection).
- Aborts of non-offered, non-active valid mailboxes: clear on the next edge and pulse fail_pulse. Aborts of invalid mailboxes are ignored.
- tx_done outside ACTIVE and tx_ack outside OFFER are ignored.
- done_pulse and fail_pulse are one cycle wide and never both set for the same mailbox.
- Asynchronous reset mid-frame clears everything immediately. The engine must discard its frame once reset is asserted.

Test Plan:
- Write mbox0 (id 0x123, dlc 2, data 0xBEEF), tx_ack at the first tx_req, then tx_done/ok -> tx_req at the write cycle +3 with tx_id=0x123, tx_data[15:0]=0xBEEF; done_pulse=0001; mbox_valid=0.
- Write mbox2 id 0x200 and mbox1 id 0x100, plus mbox3 id 0x100 remote -> offers in order mbox1, mbox3, mbox2.
- Offer mbox0 id 0x300 with tx_ack withheld, then write mbox1 id 0x050 -> tx_req drops for at least 1 cycle, then re-offers with tx_idx=1, tx_id=0x050.
- RETRY_LIMIT=3: mbox0 returns error 3 times -> offered 3 times; fail_pulse=0001 on the 3rd tx_done; no 4th tx_req.
- Abort mbox0 while ACTIVE, then tx_done/arbitration lost -> fail_pulse=0001, never re-offered. Repeat with result ok -> done_pulse=0001 only.
- Write valid mbox1 again -> wr_err pulses 1 cycle and the stored id is unchanged. Assert reset mid-ACTIVE -> all outputs 0 immediately.
